// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - RV32M multiply/divide unit: single-cycle multiply, restoring iterative divide.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] R
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state, state_n;
    logic            busy_n, done_n;

    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] quo, rem, dvs;
    logic [XLEN-1:0] spec_res;
    logic            spec_q, neg_q, neg_r;
    logic [CW-1:0]   cnt;

    // Divide special cases are decided from the raw operands at accept time.
    logic            sgn_div, b_zero, ovf, special;
    logic [XLEN-1:0] spec_val, a_abs, b_abs;

    assign sgn_div  = ~op[0];
    assign b_zero   = (B == '0);
    assign ovf      = sgn_div && (A == MINV) && (B == '1);
    assign special  = b_zero || ovf;
    assign spec_val = b_zero ? (op[1] ? A : '1) : (op[1] ? '0 : MINV);
    assign a_abs    = (sgn_div && A[XLEN-1]) ? -A : A;
    assign b_abs    = (sgn_div && B[XLEN-1]) ? -B : B;

    // Extending each operand to 2*XLEN makes one signed product cover all four multiply forms.
    logic            a_sx, b_sx;
    logic signed [2*XLEN-1:0] a_w, b_w, prod;
    logic [XLEN-1:0] mul_res;

    assign a_sx    = (op_q == 3'd1) || (op_q == 3'd2);
    assign b_sx    = (op_q == 3'd1);
    assign a_w     = {{XLEN{a_sx & a_q[XLEN-1]}}, a_q};
    assign b_w     = {{XLEN{b_sx & b_q[XLEN-1]}}, b_q};
    assign prod    = a_w * b_w;
    assign mul_res = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] q_fin, r_fin, div_res;

    assign rem_sh  = {rem, quo[XLEN-1]};
    assign diff    = rem_sh - {1'b0, dvs};
    assign q_fin   = neg_q ? -quo : quo;
    assign r_fin   = neg_r ? -rem : rem;
    assign div_res = op_q[1] ? r_fin : q_fin;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (op[2] && !special) ? DIV : MUL;
            MUL:     state_n = DONE;
            DIV:     if (cnt == CW'(XLEN)) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            spec_res <= '0;
            spec_q   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            cnt      <= '0;
            R        <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q     <= op;
                    a_q      <= A;
                    b_q      <= B;
                    spec_q   <= op[2] && special;
                    spec_res <= spec_val;
                    quo      <= a_abs;
                    dvs      <= b_abs;
                    rem      <= '0;
                    cnt      <= '0;
                    neg_q    <= sgn_div && (A[XLEN-1] ^ B[XLEN-1]);
                    neg_r    <= sgn_div && A[XLEN-1];
                end
                MUL: R <= spec_q ? spec_res : mul_res;
                DIV: begin
                    if (cnt == CW'(XLEN)) begin
                        R <= div_res;
                    end else begin
                        if (!diff[XLEN]) begin
                            rem <= diff[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], 1'b1};
                        end else begin
                            rem <= rem_sh[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
